ibuf_ctrl_sync: RTL and testbench
=================================

Name: ibuf_ctrl_sync

Overview:
- Clocked input-buffer control stage for pad inputs, WIDTH bits wide.
- Gates pad data to 0 when the buffer is disabled, either by an explicit disable or because the pad is in output mode (T=0).
- Resynchronises the gated data into the core clock domain.
- Produces per-bit edge pulses and status flags.
- Sits between the pad/IO ring and the core logic of the DDR interface.

Parameters:
- WIDTH, 1, number of pad bits handled; legal range 1..64.
- USE_IBUFDISABLE, "FALSE", "TRUE" enables data gating; "FALSE" passes pad data ungated. Any other value is an elaboration error (fatal).
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4, anything else is an elaboration error (fatal).

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i  in  WIDTH  raw pad input data (asynchronous to clk).
- ibufdisable  in  1  buffer disable request, active high.
- intermdisable  in  1  termination disable request, active high; never affects data.
- t  in  1  tristate control; 1 = pad is input, 0 = pad is driving.
- o  out  WIDTH  synchronised, gated pad data.
- rise  out  WIDTH  one-cycle pulse per bit when o goes 0->1.
- fall  out  WIDTH  one-cycle pulse per bit when o goes 1->0.
- gated  out  1  registered gate-active status.
- term_dis  out  1  registered copy of intermdisable.

Behaviour:
- Reset: asserting rst_n=0 immediately clears every flop, independent of clk. While in reset, o, rise, fall, gated and term_dis are all 0. Synchroniser chains restart from 0 after release; the same applies when reset is asserted mid-operation.
- Gate term (combinational): gate_en = (USE_IBUFDISABLE=="TRUE") && (ibufdisable || !t). With USE_IBUFDISABLE="FALSE", gate_en is constant 0.
- Gated data: d[k] = gate_en ? 0 : i[k], applied to all bits identically.
- Synchroniser: per bit, a chain of SYNC_STAGES flops; stage0 <= d, stage[n] <= stage[n-1]. o = last stage.
- Latency: a stable change on i appears on o exactly SYNC_STAGES rising edges later. Gating changes (ibufdisable/t) follow the same path and the same latency.
- Edge pulses are registered and asserted in the same cycle o changes:
  - rise[k] <= stage[N-2][k] & ~stage[N-1][k]
  - fall[k] <= ~stage[N-2][k] & stage[N-1][k]
  - Each pulse lasts exactly one cycle per transition. rise and fall are never both high for the same bit.
- gated <= gate_en (1-cycle latency); always 0 when USE_IBUFDISABLE="FALSE".
- term_dis <= intermdisable (1-cycle latency). It is status only: no effect on o, rise, fall or gated.
- Simultaneous events:
  - Gate asserting while i rises: d stays 0, so no rise pulse.
  - Gate releasing while i=1: o goes high SYNC_STAGES cycles later, with a rise pulse.
- Toggling i faster than one clock may be missed; that is acceptable, with no X propagation from the gating logic.
- No handshake; the block is free-running.
- Implementation form: synthesizable, no X literals, no delays, generate loops over WIDTH and SYNC_STAGES.

Test Plan:
- Reset mid-run: WIDTH=4, i=4'hF held, rst_n pulsed low for 3 cycles -> o=0, rise=0, gated=0 during reset. After release, o=4'hF appears on the 2nd clock with rise=4'hF for exactly 1 cycle.
- Pass-through mode: USE_IBUFDISABLE="FALSE", ibufdisable=1, t=0, i=4'hA -> o=4'hA after 2 cycles, gated stays 0.
- Gating by disable: USE_IBUFDISABLE="TRUE", t=1, i=4'hF steady with o=4'hF; set ibufdisable=1 -> gated=1 after 1 cycle, o=0 after 2 cycles, fall=4'hF for 1 cycle. Clear ibufdisable -> o=4'hF after 2 cycles, rise=4'hF.
- Gating by output mode: USE_IBUFDISABLE="TRUE", ibufdisable=0, t=0, i toggling -> o stays 0, no rise/fall pulses. Set t=1 -> o tracks i with 2-cycle latency.
- Depth check: SYNC_STAGES=4, i steps 0->1 on bit 0 -> o[0]=1 exactly 4 edges later, rise[0] high in that same cycle only.
- Termination status: intermdisable pulsed 1 for 2 cycles -> term_dis high for 2 cycles with 1-cycle lag; o unchanged throughout.

Source files
------------

// File: rtl/ibuf_ctrl_sync.sv
// ibuf_ctrl_sync: clocked input-buffer control stage for pad inputs.
//
// Pad data is forced to 0 while the buffer is disabled, either by request
// or because the pad is driving. The gated data then passes through a
// SYNC_STAGES-deep synchroniser into the clk domain. The block also
// produces per-bit edge pulses and registered status flags.
//
// Ports:
//   clk           core clock, rising-edge active
//   rst_n         asynchronous active-low reset, clears every flop
//   i             raw pad data, asynchronous to clk
//   ibufdisable   buffer disable request, active high
//   intermdisable termination disable request, active high (status only)
//   t             tristate control, 1 = pad is input, 0 = pad is driving
//   o             synchronised, gated pad data
//   rise          one-cycle pulse per bit when o goes 0->1
//   fall          one-cycle pulse per bit when o goes 1->0
//   gated         registered gate-active status
//   term_dis      registered copy of intermdisable
module ibuf_ctrl_sync #(
    parameter int unsigned WIDTH           = 1,
    parameter string       USE_IBUFDISABLE = "FALSE",
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i,
    input  logic             ibufdisable,
    input  logic             intermdisable,
    input  logic             t,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             gated,
    output logic             term_dis
);

    // Reject illegal configurations at elaboration time.
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $fatal(1, "ibuf_ctrl_sync: WIDTH must be in 1..64");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $fatal(1, "ibuf_ctrl_sync: SYNC_STAGES must be in 2..4");
    end
    if (USE_IBUFDISABLE != "TRUE" && USE_IBUFDISABLE != "FALSE") begin : g_bad_use
        $fatal(1, "ibuf_ctrl_sync: USE_IBUFDISABLE must be \"TRUE\" or \"FALSE\"");
    end

    localparam bit UseGate = (USE_IBUFDISABLE == "TRUE");

    logic             gate_en;
    logic [WIDTH-1:0] data_gated;

    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    logic [WIDTH-1:0] rise_d, rise_q;
    logic [WIDTH-1:0] fall_d, fall_q;
    logic             gated_d, gated_q;
    logic             term_dis_d, term_dis_q;

    // Gate is constant 0 when gating is not configured, so the pad passes through.
    assign gate_en = UseGate & (ibufdisable | ~t);

    for (genvar k = 0; k < WIDTH; k++) begin : g_gate
        assign data_gated[k] = gate_en ? 1'b0 : i[k];
    end

    // Synchroniser chain: stage 0 samples the gated pad data.
    assign sync_d[0] = data_gated;
    for (genvar s = 1; s < SYNC_STAGES; s++) begin : g_chain
        assign sync_d[s] = sync_q[s-1];
    end

    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync_ff
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q[s] <= '0;
            end else begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    // Edge detect on the value about to enter the last stage, so the pulse
    // is registered in the same cycle that o changes.
    always_comb begin
        rise_d     = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
        fall_d     = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
        gated_d    = gate_en;
        term_dis_d = intermdisable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q     <= '0;
            fall_q     <= '0;
            gated_q    <= 1'b0;
            term_dis_q <= 1'b0;
        end else begin
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            gated_q    <= gated_d;
            term_dis_q <= term_dis_d;
        end
    end

    always_comb begin
        o        = sync_q[SYNC_STAGES-1];
        rise     = rise_q;
        fall     = fall_q;
        gated    = gated_q;
        term_dis = term_dis_q;
    end

endmodule

// File: tb/tb_ibuf_ctrl_sync.sv
module tb_ibuf_ctrl_sync;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A: gating enabled, 2 stages.
    logic [3:0] i_a, o_a, rise_a, fall_a;
    logic       ibd_a, imd_a, t_a, gated_a, term_a;
    // Instance B: pass-through, 2 stages.
    logic [3:0] i_b, o_b, rise_b, fall_b;
    logic       ibd_b, imd_b, t_b, gated_b, term_b;
    // Instance C: gating enabled, 4 stages.
    logic [3:0] i_c, o_c, rise_c, fall_c;
    logic       ibd_c, imd_c, t_c, gated_c, term_c;

    int n_checks = 0;
    int n_pass   = 0;

    ibuf_ctrl_sync #(.WIDTH(4), .USE_IBUFDISABLE("TRUE"), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .i(i_a), .ibufdisable(ibd_a), .intermdisable(imd_a),
        .t(t_a), .o(o_a), .rise(rise_a), .fall(fall_a), .gated(gated_a), .term_dis(term_a)
    );

    ibuf_ctrl_sync #(.WIDTH(4), .USE_IBUFDISABLE("FALSE"), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i(i_b), .ibufdisable(ibd_b), .intermdisable(imd_b),
        .t(t_b), .o(o_b), .rise(rise_b), .fall(fall_b), .gated(gated_b), .term_dis(term_b)
    );

    ibuf_ctrl_sync #(.WIDTH(4), .USE_IBUFDISABLE("TRUE"), .SYNC_STAGES(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .i(i_c), .ibufdisable(ibd_c), .intermdisable(imd_c),
        .t(t_c), .o(o_c), .rise(rise_c), .fall(fall_c), .gated(gated_c), .term_dis(term_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all of instance A's outputs at once.
    task automatic chk_a(input string tag, input logic [3:0] eo, input logic [3:0] er,
                         input logic [3:0] ef, input logic eg, input logic et);
        check({tag, ".o"}, 64'(o_a), 64'(eo));
        check({tag, ".rise"}, 64'(rise_a), 64'(er));
        check({tag, ".fall"}, 64'(fall_a), 64'(ef));
        check({tag, ".gated"}, 64'(gated_a), 64'(eg));
        check({tag, ".term"}, 64'(term_a), 64'(et));
    endtask

    initial begin
        rst_n = 1'b0;
        i_a = 4'h0; ibd_a = 1'b0; imd_a = 1'b0; t_a = 1'b1;
        i_b = 4'h0; ibd_b = 1'b1; imd_b = 1'b0; t_b = 1'b0;
        i_c = 4'h0; ibd_c = 1'b0; imd_c = 1'b0; t_c = 1'b1;
        step();
        step();
        chk_a("rst0", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        check("rst0.b.o", 64'(o_b), 64'h0);
        check("rst0.c.o", 64'(o_c), 64'h0);

        // Release reset with data already present on A and B.
        i_a = 4'hF;
        i_b = 4'hA;
        rst_n = 1'b1;
        step();
        chk_a("rel.e1", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        check("pass.e1.o", 64'(o_b), 64'h0);
        check("pass.e1.gated", 64'(gated_b), 64'h0);
        step();
        chk_a("rel.e2", 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        check("pass.e2.o", 64'(o_b), 64'hA);
        check("pass.e2.rise", 64'(rise_b), 64'hA);
        check("pass.e2.gated", 64'(gated_b), 64'h0);
        step();
        chk_a("rel.e3", 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        check("pass.e3.o", 64'(o_b), 64'hA);
        check("pass.e3.rise", 64'(rise_b), 64'h0);

        // Depth check on instance C: 4 edges of latency.
        i_c = 4'h1;
        for (int n = 1; n <= 3; n++) begin
            step();
            check($sformatf("depth.e%0d.o", n), 64'(o_c), 64'h0);
            check($sformatf("depth.e%0d.rise", n), 64'(rise_c), 64'h0);
        end
        step();
        check("depth.e4.o", 64'(o_c), 64'h1);
        check("depth.e4.rise", 64'(rise_c), 64'h1);
        step();
        check("depth.e5.o", 64'(o_c), 64'h1);
        check("depth.e5.rise", 64'(rise_c), 64'h0);

        // Mid-run reset: takes effect without a clock edge.
        rst_n = 1'b0;
        #1;
        chk_a("mrst.async", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        check("mrst.async.c", 64'(o_c), 64'h0);
        for (int n = 1; n <= 3; n++) begin
            step();
            chk_a($sformatf("mrst.c%0d", n), 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        step();
        chk_a("mrel.e1", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        step();
        chk_a("mrel.e2", 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        step();
        chk_a("mrel.e3", 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);

        // Gating by explicit disable.
        ibd_a = 1'b1;
        step();
        chk_a("dis.e1", 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        step();
        chk_a("dis.e2", 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
        step();
        chk_a("dis.e3", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        ibd_a = 1'b0;
        step();
        chk_a("en.e1", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        step();
        chk_a("en.e2", 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        step();
        chk_a("en.e3", 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);

        // Gating by output mode (t=0).
        t_a = 1'b0;
        step();
        chk_a("tout.e1", 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        step();
        chk_a("tout.e2", 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) begin
            i_a = (n % 2 == 0) ? 4'h5 : 4'hA;
            step();
            chk_a($sformatf("tout.tog%0d", n), 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        end
        t_a = 1'b1;
        i_a = 4'h5;
        step();
        chk_a("tin.e1", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        step();
        chk_a("tin.e2", 4'h5, 4'h5, 4'h0, 1'b0, 1'b0);
        i_a = 4'hA;
        step();
        chk_a("trk.e1", 4'h5, 4'h0, 4'h0, 1'b0, 1'b0);
        step();
        chk_a("trk.e2", 4'hA, 4'hA, 4'h5, 1'b0, 1'b0);

        // Termination status: 1-cycle lag, no effect on data.
        imd_a = 1'b1;
        step();
        chk_a("term.e1", 4'hA, 4'h0, 4'h0, 1'b0, 1'b1);
        step();
        chk_a("term.e2", 4'hA, 4'h0, 4'h0, 1'b0, 1'b1);
        imd_a = 1'b0;
        step();
        chk_a("term.e3", 4'hA, 4'h0, 4'h0, 1'b0, 1'b0);

        // Gate asserts while i rises: no rise pulse, old ones fall.
        i_a = 4'hF;
        ibd_a = 1'b1;
        step();
        chk_a("sim.e1", 4'hA, 4'h0, 4'h0, 1'b1, 1'b0);
        step();
        chk_a("sim.e2", 4'h0, 4'h0, 4'hA, 1'b1, 1'b0);
        step();
        chk_a("sim.e3", 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
